measure_sequencer: RTL

- Parametrised successor of the single-shot measurement FSM.
- Runs one measurement cycle per `enable`:
  - an auto-range pass first;
  - then every mode enabled in `mode_mask`, each over NUM_PHASES mux phases.
- Drives the key/range register over the shared DAC/register SPI, the sine generator enable, the analog mux and the ADC reader.
- Streams tagged results through a valid/ready port to the FIFO, with backpressure, timeouts and abort.

---
 rtl/measure_pkg.sv | 52 +++++
 rtl/measure_sequencer_timer.sv | 34 +++
 rtl/measure_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/measure_pkg.sv
// Shared definitions for the measurement sequencer: state codes, chip-select,
// mux and range encodings, and the output tag layout.
package measure_pkg;

    typedef logic [4:0] state_t;

    localparam state_t S_IDLE        = 5'd0;
    localparam state_t S_RANGE_SETUP = 5'd1;
    localparam state_t S_SET_REG     = 5'd2;
    localparam state_t S_WAIT_REG    = 5'd3;
    localparam state_t S_GEN_ON      = 5'd4;
    localparam state_t S_SET_MUX     = 5'd5;
    localparam state_t S_SETTLE      = 5'd6;
    localparam state_t S_ADC_START   = 5'd7;
    localparam state_t S_ADC_WAIT    = 5'd8;
    localparam state_t S_RANGE_EVAL  = 5'd9;
    localparam state_t S_PUSH1       = 5'd10;
    localparam state_t S_PUSH2       = 5'd11;
    localparam state_t S_NEXT_PHASE  = 5'd12;
    localparam state_t S_GEN_OFF     = 5'd13;
    localparam state_t S_MUX_OFF     = 5'd14;
    localparam state_t S_NEXT_MODE   = 5'd15;
    localparam state_t S_DONE        = 5'd16;

    localparam logic [1:0] CS_NONE = 2'b11;
    localparam logic [1:0] CS_REG  = 2'b10;
    localparam logic [1:0] CS_DAC  = 2'b01;

    localparam logic [2:0] MUX_NONE    = 3'b000;
    localparam logic [2:0] MUX_MN_NM   = 3'b001;
    localparam logic [2:0] MUX_CURRENT = 3'b010;

    localparam logic [2:0] DIAP_5V  = 3'b001;
    localparam logic [2:0] DIAP_10V = 3'b010;
    localparam logic [2:0] DIAP_20V = 3'b100;

    localparam int unsigned TAG_WORD_BIT  = 0;
    localparam int unsigned TAG_PHASE_LSB = 1;
    localparam int unsigned TAG_MODE_LSB  = 3;

    function automatic logic [5:0] make_tag(input logic [2:0] mode,
                                            input logic [1:0] phase,
                                            input logic       word);
        logic [5:0] t;
        t = '0;
        t[TAG_MODE_LSB +: 3]  = mode;
        t[TAG_PHASE_LSB +: 2] = phase;
        t[TAG_WORD_BIT]       = word;
        return t;
    endfunction

endpackage

// File: rtl/measure_sequencer_timer.sv
// seq_timer: loadable down-counter ticking either on generator periods or on
// every clock; expired flags a tick that arrives with the count already at zero.
module seq_timer #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             period_mode,
    input  logic [WIDTH-1:0] load_value,
    input  logic             gen_new_period,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic             period_r;
    logic             tick;

    assign tick    = period_r ? gen_new_period : 1'b1;
    assign expired = tick && (count == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            period_r <= 1'b0;
        end else if (load) begin
            count    <= load_value;
            period_r <= period_mode;
        end else if (tick && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/measure_sequencer.sv
// Multi-mode measurement sequencer: an auto-range pass, then every enabled mode
// over NUM_PHASES mux phases, streaming tagged ADC words through valid/ready.
module measure_sequencer
    import measure_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH     = 24,
    parameter int unsigned               NUM_MODES      = 5,
    parameter int unsigned               NUM_PHASES     = 2,
    parameter int unsigned               KEY_WIDTH      = 5,
    parameter logic [3*NUM_PHASES-1:0]   PHASE_MUX      = {MUX_MN_NM, MUX_CURRENT},
    parameter int unsigned               SETTLE_PERIODS = 2,
    parameter logic [DATA_WIDTH-1:0]     TH_5V          = DATA_WIDTH'(24'h200000),
    parameter logic [DATA_WIDTH-1:0]     TH_10V         = DATA_WIDTH'(24'h400000),
    parameter int unsigned               TIMEOUT_CYCLES = 65535
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              abort,
    input  logic [NUM_MODES-1:0]              mode_mask,
    input  logic [(NUM_MODES+1)*KEY_WIDTH-1:0] mode_keys,
    output logic [1:0]                        cs_dac_reg,
    output logic                              reg_start,
    output logic [7:0]                        reg_data,
    input  logic                              reg_done,
    output logic                              gen_enable,
    input  logic                              gen_new_period,
    output logic [2:0]                        mux_chn,
    output logic                              adc_start,
    output logic                              adc_read_diapason,
    input  logic                              adc_done,
    input  logic [DATA_WIDTH-1:0]             adc_data_1,
    input  logic [DATA_WIDTH-1:0]             adc_data_2,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [5:0]                        out_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [2:0]                        diap,
    output logic                              busy,
    output logic                              cycle_done,
    output logic                              error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + SETTLE_PERIODS + 1) + 1;
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_PERIODS);

    state_t                  state;
    logic [2:0]              mode;
    logic [1:0]              phase;
    logic                    stop;
    logic [DATA_WIDTH-1:0]   d1;
    logic [DATA_WIDTH-1:0]   d2;

    logic                    tmr_load;
    logic                    tmr_period;
    logic [TW-1:0]           tmr_value;
    logic                    tmr_expired;
    logic [KEY_WIDTH-1:0]    cur_key;
    logic [2:0]              phase_code;
    logic                    next_found;
    logic [2:0]              next_mode;

    seq_timer #(.WIDTH(TW)) u_timer (
        .clk            (clk),
        .rst            (rst),
        .load           (tmr_load),
        .period_mode    (tmr_period),
        .load_value     (tmr_value),
        .gen_new_period (gen_new_period),
        .expired        (tmr_expired)
    );

    // One timer serves both the settle wait (period ticks) and the timeouts (clock ticks).
    always_comb begin
        tmr_load   = 1'b0;
        tmr_period = 1'b0;
        tmr_value  = TIMEOUT_LOAD;
        case (state)
            S_SET_REG, S_ADC_START: tmr_load = 1'b1;
            S_SET_MUX: begin
                tmr_load   = 1'b1;
                tmr_period = 1'b1;
                tmr_value  = SETTLE_LOAD;
            end
            default: ;
        endcase
    end

    always_comb begin
        cur_key    = mode_keys[32'(mode) * KEY_WIDTH +: KEY_WIDTH];
        phase_code = PHASE_MUX[32'(phase) * 3 +: 3];
        next_found = 1'b0;
        next_mode  = '0;
        for (int unsigned m = 1; m <= NUM_MODES; m++) begin
            if (!next_found && (m > 32'(mode)) && mode_mask[m-1]) begin
                next_found = 1'b1;
                next_mode  = 3'(m);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= S_IDLE;
            mode              <= '0;
            phase             <= '0;
            stop              <= 1'b0;
            d1                <= '0;
            d2                <= '0;
            cs_dac_reg        <= CS_NONE;
            reg_start         <= 1'b0;
            reg_data          <= '0;
            gen_enable        <= 1'b0;
            mux_chn           <= MUX_NONE;
            adc_start         <= 1'b0;
            adc_read_diapason <= 1'b0;
            out_data          <= '0;
            out_tag           <= '0;
            out_valid         <= 1'b0;
            diap              <= DIAP_20V;
            busy              <= 1'b0;
            cycle_done        <= 1'b0;
            error             <= 1'b0;
        end else begin
            reg_start  <= 1'b0;
            adc_start  <= 1'b0;
            cycle_done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                out_valid         <= 1'b0;
                adc_read_diapason <= 1'b0;
                stop              <= 1'b1;
                state             <= S_GEN_OFF;
            end else begin
                case (state)
                    S_IDLE: if (enable) begin
                        busy  <= 1'b1;
                        mode  <= '0;
                        phase <= '0;
                        diap  <= DIAP_20V;
                        error <= 1'b0;
                        stop  <= 1'b0;
                        state <= S_RANGE_SETUP;
                    end
                    S_RANGE_SETUP: state <= S_SET_REG;
                    S_SET_REG: begin
                        cs_dac_reg <= CS_REG;
                        reg_data   <= 8'({diap, cur_key});
                        reg_start  <= 1'b1;
                        state      <= S_WAIT_REG;
                    end
                    S_WAIT_REG: begin
                        if (reg_done) begin
                            state <= S_GEN_ON;
                        end else if (tmr_expired) begin
                            error <= 1'b1;
                            stop  <= 1'b1;
                            state <= S_GEN_OFF;
                        end
                    end
                    S_GEN_ON: begin
                        gen_enable <= 1'b1;
                        cs_dac_reg <= CS_DAC;
                        state      <= S_SET_MUX;
                    end
                    S_SET_MUX: begin
                        mux_chn <= phase_code;
                        state   <= S_SETTLE;
                    end
                    S_SETTLE: if (tmr_expired) state <= S_ADC_START;
                    S_ADC_START: begin
                        adc_start         <= 1'b1;
                        adc_read_diapason <= (mode == '0);
                        state             <= S_ADC_WAIT;
                    end
                    S_ADC_WAIT: begin
                        if (adc_done) begin
                            d1                <= adc_data_1;
                            d2                <= adc_data_2;
                            adc_read_diapason <= 1'b0;
                            if (mode == '0) begin
                                state <= S_RANGE_EVAL;
                            end else begin
                                out_data  <= adc_data_1;
                                out_tag   <= make_tag(mode, phase, 1'b0);
                                out_valid <= 1'b1;
                                state     <= S_PUSH1;
                            end
                        end else if (tmr_expired) begin
                            adc_read_diapason <= 1'b0;
                            error             <= 1'b1;
                            stop              <= 1'b1;
                            state             <= S_GEN_OFF;
                        end
                    end
                    S_RANGE_EVAL: begin
                        if (d1 < TH_5V)       diap <= DIAP_5V;
                        else if (d1 < TH_10V) diap <= DIAP_10V;
                        else                  diap <= DIAP_20V;
                        state <= S_GEN_OFF;
                    end
                    // Word 1 is loaded on the word-0 handshake so both words go out back-to-back.
                    S_PUSH1: if (out_ready) begin
                        out_data <= d2;
                        out_tag  <= make_tag(mode, phase, 1'b1);
                        state    <= S_PUSH2;
                    end
                    S_PUSH2: if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_NEXT_PHASE;
                    end
                    S_NEXT_PHASE: begin
                        if (32'(phase) < NUM_PHASES - 1) begin
                            phase <= phase + 2'd1;
                            state <= S_SET_MUX;
                        end else begin
                            state <= S_GEN_OFF;
                        end
                    end
                    S_GEN_OFF: begin
                        gen_enable <= 1'b0;
                        cs_dac_reg <= CS_NONE;
                        state      <= S_MUX_OFF;
                    end
                    S_MUX_OFF: begin
                        mux_chn <= MUX_NONE;
                        state   <= stop ? S_DONE : S_NEXT_MODE;
                    end
                    S_NEXT_MODE: begin
                        if (next_found) begin
                            mode  <= next_mode;
                            phase <= '0;
                            state <= S_SET_REG;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        cycle_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
